// File: rtl/controller_poller.sv
// Serial game-controller poller: issues a latch strobe and 16 shift clocks once per
// poll period, captures the inverted serial data and tracks sticky press edges.
module controller_poller #(
    parameter int CLK_DIV     = 150,
    parameter int POLL_PERIOD = 416667
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ctrl_latch,
    output logic        ctrl_clk,
    input  logic        ctrl_data,
    output logic [15:0] buttons,
    output logic        buttons_valid,
    output logic [15:0] pressed_edge,
    input  logic        read_ack,
    output logic [2:0]  dbg_state
);

    localparam int PH_W   = $clog2(2 * CLK_DIV);
    localparam int POLL_W = $clog2(POLL_PERIOD);

    localparam logic [PH_W-1:0]   PH_ONE     = PH_W'(1);
    localparam logic [PH_W-1:0]   LATCH_END  = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0]   HALF_END   = PH_W'(CLK_DIV - 1);
    localparam logic [POLL_W-1:0] POLL_ONE   = POLL_W'(1);
    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LATCH      = 3'd1,
        SHIFT_HIGH = 3'd2,
        SHIFT_LOW  = 3'd3,
        DONE       = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic [3:0]          idx_q, idx_d;
    logic [15:0]         shift_q, shift_d;
    logic [15:0]         buttons_q, buttons_d;
    logic [15:0]         pe_q, pe_d;
    logic [POLL_W-1:0]   poll_q, poll_d;
    logic [1:0]          sync_q, sync_d;
    logic                latch_q, latch_d;
    logic                sclk_q, sclk_d;
    logic                valid_q, valid_d;
    logic                tick;

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q + PH_ONE;
        idx_d     = idx_q;
        shift_d   = shift_q;
        buttons_d = buttons_q;
        pe_d      = read_ack ? 16'h0000 : pe_q;
        sync_d    = {sync_q[0], ctrl_data};
        tick      = (poll_q == '0);
        poll_d    = (poll_q == POLL_LAST) ? '0 : poll_q + POLL_ONE;

        case (state_q)
            IDLE: begin
                ph_d = '0;
                if (tick) state_d = LATCH;
            end
            LATCH: begin
                if (ph_q == LATCH_END) begin
                    state_d = SHIFT_HIGH;
                    ph_d    = '0;
                    idx_d   = 4'd0;
                end
            end
            SHIFT_HIGH: begin
                if (ph_q == HALF_END) begin
                    shift_d[idx_q] = ~sync_q[1];
                    state_d        = SHIFT_LOW;
                    ph_d           = '0;
                end
            end
            SHIFT_LOW: begin
                if (ph_q == HALF_END) begin
                    ph_d  = '0;
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        // Frame commits on the edge entering DONE; a coincident
                        // read_ack clears old flags but new edges are kept.
                        state_d   = DONE;
                        buttons_d = shift_q;
                        pe_d      = pe_d | (shift_q & ~buttons_q);
                    end else begin
                        state_d = SHIFT_HIGH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                ph_d    = '0;
            end
            default: state_d = IDLE;
        endcase

        latch_d = (state_d == LATCH);
        sclk_d  = (state_d != SHIFT_LOW);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ph_q      <= '0;
            idx_q     <= 4'd0;
            shift_q   <= 16'h0000;
            buttons_q <= 16'h0000;
            pe_q      <= 16'h0000;
            poll_q    <= '0;
            sync_q    <= 2'b11;
            latch_q   <= 1'b0;
            sclk_q    <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            buttons_q <= buttons_d;
            pe_q      <= pe_d;
            poll_q    <= poll_d;
            sync_q    <= sync_d;
            latch_q   <= latch_d;
            sclk_q    <= sclk_d;
            valid_q   <= valid_d;
        end
    end

    assign ctrl_latch    = latch_q;
    assign ctrl_clk      = sclk_q;
    assign buttons       = buttons_q;
    assign buttons_valid = valid_q;
    assign pressed_edge  = pe_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_controller_poller.sv
// Bench for controller_poller: a serial controller model feeds patterns, and a
// frame-level model of buttons / press-edge rules provides the expected values.
module tb_controller_poller;

    logic        clk;
    logic        rst_n;
    logic        ctrl_latch;
    logic        ctrl_clk;
    logic        ctrl_data;
    logic [15:0] buttons;
    logic        buttons_valid;
    logic [15:0] pressed_edge;
    logic        read_ack;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    controller_poller #(.CLK_DIV(4), .POLL_PERIOD(200)) dut (
        .clk(clk), .rst_n(rst_n), .ctrl_latch(ctrl_latch), .ctrl_clk(ctrl_clk),
        .ctrl_data(ctrl_data), .buttons(buttons), .buttons_valid(buttons_valid),
        .pressed_edge(pressed_edge), .read_ack(read_ack), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // controller model: latch presents bit 0, each ctrl_clk rise shifts to the next bit
    logic [15:0] pattern = 16'h0000;
    int          bit_idx = 16;
    always @(posedge ctrl_latch or posedge ctrl_clk) begin
        if (ctrl_latch) bit_idx = 0;
        else            bit_idx = bit_idx + 1;
    end
    assign ctrl_data = (bit_idx < 16) ? ~pattern[bit_idx[3:0]] : 1'b1;

    // scoreboard / reference model
    logic [15:0] exp_q[$];
    logic [15:0] exp_prev = 16'h0000;
    logic [15:0] exp_pe   = 16'h0000;

    task automatic model_frame(input logic [15:0] pat, input bit ack_done);
        exp_pe   = (ack_done ? 16'h0000 : exp_pe) | (pat & ~exp_prev);
        exp_prev = pat;
        exp_q.push_back(pat);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // driver: one poll frame, optionally with read_ack on the committing edge
    task automatic run_frame(input logic [15:0] pat, input bit ack_done,
                             output logic [15:0] b_obs, output logic [15:0] pe_obs,
                             output int lat_cyc, output int valid_off, output bit ok);
        pattern   = pat;
        ok        = 1'b0;
        lat_cyc   = -1;
        valid_off = -1;
        b_obs     = 16'h0000;
        pe_obs    = 16'h0000;
        for (int k = 0; k < 400 && lat_cyc < 0; k++) begin
            tick();
            if (ctrl_latch) lat_cyc = cyc;
        end
        if (lat_cyc < 0) return;
        for (int k = 0; k < 200; k++) begin
            tick();
            read_ack = ack_done && (cyc - lat_cyc == 135);
            if (buttons_valid) begin
                valid_off = cyc - lat_cyc;
                b_obs     = buttons;
                pe_obs    = pressed_edge;
                ok        = 1'b1;
                break;
            end
        end
        read_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        read_ack = 1'b0;
        repeat (3) tick();
        checks++; if (ctrl_latch !== 1'b0)       begin errors++; $display("FAIL reset_latch: got %b expected 0", ctrl_latch); end
        checks++; if (ctrl_clk !== 1'b1)         begin errors++; $display("FAIL reset_clk: got %b expected 1", ctrl_clk); end
        checks++; if (buttons !== 16'h0000)      begin errors++; $display("FAIL reset_buttons: got %h expected 0000", buttons); end
        checks++; if (buttons_valid !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %b expected 0", buttons_valid); end
        checks++; if (pressed_edge !== 16'h0000) begin errors++; $display("FAIL reset_edge: got %h expected 0000", pressed_edge); end
        checks++; if (dbg_state !== 3'd0)        begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_frame_timing();
        int  rises[$];
        int  valids[$];
        int  latch_hi = 0, low_run = 0, pulses = 0, bad_run = 0, overlap = 0, bad_val = 0;
        bit  prev_latch = 1'b0;
        bit  rise_ok = 1'b1, valid_ok = 1'b1;
        pattern = 16'h0000;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (ctrl_latch && !prev_latch) rises.push_back(cyc);
            if (ctrl_latch) latch_hi++;
            if (ctrl_latch && !ctrl_clk) overlap++;
            if (!ctrl_clk) low_run++;
            else if (low_run > 0) begin
                pulses++;
                if (low_run != 4) bad_run++;
                low_run = 0;
            end
            if (buttons_valid) begin
                valids.push_back(cyc);
                if (buttons !== 16'h0000 || pressed_edge !== 16'h0000) bad_val++;
            end
            prev_latch = ctrl_latch;
        end
        if (rises.size() != 3) rise_ok = 1'b0;
        else foreach (rises[i]) if (rises[i] != 1 + 200 * i) rise_ok = 1'b0;
        if (valids.size() != 3) valid_ok = 1'b0;
        else foreach (valids[i]) if (valids[i] != 137 + 200 * i) valid_ok = 1'b0;
        checks++; if (!rise_ok)       begin errors++; $display("FAIL latch_starts: got %0d rises first=%0d expected 3 at 1,201,401", rises.size(), (rises.size() > 0) ? rises[0] : -1); end
        checks++; if (latch_hi != 24) begin errors++; $display("FAIL latch_width: got %0d cycles expected 24", latch_hi); end
        checks++; if (pulses != 48)   begin errors++; $display("FAIL clk_pulses: got %0d expected 48", pulses); end
        checks++; if (bad_run != 0)   begin errors++; $display("FAIL clk_low_len: got %0d bad pulses expected 0", bad_run); end
        checks++; if (overlap != 0)   begin errors++; $display("FAIL clk_latch_overlap: got %0d expected 0", overlap); end
        checks++; if (!valid_ok)      begin errors++; $display("FAIL valid_cycles: got %0d pulses first=%0d expected 3 at 137,337,537", valids.size(), (valids.size() > 0) ? valids[0] : -1); end
        checks++; if (bad_val != 0)   begin errors++; $display("FAIL idle_frame_values: got %0d nonzero frames expected 0", bad_val); end
        exp_prev = 16'h0000;
        exp_pe   = 16'h0000;
    endtask

    task automatic frame_and_check(input string name, input logic [15:0] pat, input bit ack_done);
        logic [15:0] b, pe, exp_b;
        int          lc, voff;
        bit          ok;
        model_frame(pat, ack_done);
        run_frame(pat, ack_done, b, pe, lc, voff, ok);
        exp_b = exp_q.pop_front();
        checks++; if (!ok || voff != 136) begin errors++; $display("FAIL %s_latency: got %0d expected 136", name, voff); end
        checks++; if (b !== exp_b)        begin errors++; $display("FAIL %s_buttons: got %h expected %h", name, b, exp_b); end
        checks++; if (pe !== exp_pe)      begin errors++; $display("FAIL %s_edge: got %h expected %h", name, pe, exp_pe); end
    endtask

    task automatic test_pattern();
        frame_and_check("pattern_first", 16'hA5C3, 1'b0);
        frame_and_check("pattern_repeat", 16'hA5C3, 1'b0);
    endtask

    task automatic test_read_ack();
        repeat (10) tick();
        read_ack = 1'b1;
        tick();
        read_ack = 1'b0;
        exp_pe = 16'h0000;
        checks++; if (pressed_edge !== exp_pe) begin errors++; $display("FAIL idle_ack_clear: got %h expected %h", pressed_edge, exp_pe); end
        frame_and_check("new_bit2", 16'hA5C7, 1'b0);
    endtask

    task automatic test_ack_in_done();
        frame_and_check("release_bit15", 16'h25C7, 1'b0);
        frame_and_check("ack_done_bit15", 16'hA5C7, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            logic [15:0] pat;
            pat = 16'($urandom_range(0, 65535)) | 16'h0001;
            frame_and_check("random", pat, ($urandom_range(0, 1) == 1));
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] b, pe, pat;
        int          lc = -1, voff, valid_seen = 0;
        bit          ok;
        pattern = 16'h3C5A;
        for (int k = 0; k < 400 && lc < 0; k++) begin
            tick();
            if (ctrl_latch) lc = cyc;
        end
        while (lc >= 0 && cyc < lc + 69) tick();
        checks++; if (ctrl_clk !== 1'b0 || dbg_state !== 3'd3) begin errors++; $display("FAIL bit7_shift_low: got clk=%b state=%0d expected clk=0 state=3", ctrl_clk, dbg_state); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ctrl_latch !== 1'b0 || ctrl_clk !== 1'b1) begin errors++; $display("FAIL async_reset_pins: got latch=%b clk=%b expected 0 1", ctrl_latch, ctrl_clk); end
        checks++; if (buttons !== 16'h0000 || pressed_edge !== 16'h0000) begin errors++; $display("FAIL async_reset_regs: got %h %h expected 0000 0000", buttons, pressed_edge); end
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL async_reset_state: got %0d expected 0", dbg_state); end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (buttons_valid) valid_seen++;
        end
        checks++; if (valid_seen != 0) begin errors++; $display("FAIL abort_no_valid: got %0d expected 0", valid_seen); end
        rst_n = 1'b1;
        cyc   = 0;
        exp_prev = 16'h0000;
        exp_pe   = 16'h0000;
        exp_q.delete();
        pat = 16'($urandom_range(1, 65535));
        model_frame(pat, 1'b0);
        run_frame(pat, 1'b0, b, pe, lc, voff, ok);
        checks++; if (lc != 1)                 begin errors++; $display("FAIL restart_latch: got cycle %0d expected 1", lc); end
        checks++; if (!ok || voff != 136)      begin errors++; $display("FAIL restart_latency: got %0d expected 136", voff); end
        checks++; if (b !== exp_q.pop_front()) begin errors++; $display("FAIL restart_buttons: got %h expected %h", b, pat); end
        checks++; if (pe !== exp_pe)           begin errors++; $display("FAIL restart_edge: got %h expected %h", pe, exp_pe); end
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_pattern();
        test_read_ack();
        test_ack_in_done();
        test_random();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controller_poller.md
CONTROLLER_POLLER -- requirements
Module: controller_poller

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 150, giving ctrl_clk half-period and latch half-width in clk cycles (6 us at 25 MHz); legal range 4..1023.
REQ-002 The block SHALL have parameter POLL_PERIOD, default 416667, giving clk cycles between poll frame starts (~60 Hz); legal range >= 34*CLK_DIV+2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port ctrl_latch, output, 1 bit: controller latch strobe, active-high.
REQ-006 The block SHALL have port ctrl_clk, output, 1 bit: controller shift clock, idle high.
REQ-007 The block SHALL have port ctrl_data, input, 1 bit: asynchronous serial button data, low = pressed.
REQ-008 The block SHALL have port buttons, output, 16 bits: last complete frame, 1 = pressed, bit i = i-th serial bit.
REQ-009 The block SHALL have port buttons_valid, output, 1 bit: one-cycle pulse when buttons updates.
REQ-010 The block SHALL have port pressed_edge, output, 16 bits: sticky press-edge flags, one per button.
REQ-011 The block SHALL have port read_ack, input, 1 bit: one-cycle pulse from CPU that clears all pressed_edge bits.

Function
REQ-012 ctrl_data SHALL pass through a two-flop synchronizer; only the synchronized value is sampled.
REQ-013 FSM SHALL have states IDLE, LATCH, SHIFT_HIGH, SHIFT_LOW, DONE.
REQ-014 A free-running poll counter SHALL count 0..POLL_PERIOD-1 and wrap; each wrap to 0 is a poll tick; the first tick is the first clk edge after rst_n deasserts.
REQ-015 IDLE: ctrl_latch=0, ctrl_clk=1; a poll tick moves to LATCH; a tick outside IDLE is ignored.
REQ-016 LATCH: ctrl_latch=1, ctrl_clk=1 for exactly 2*CLK_DIV cycles, then SHIFT_HIGH with bit index 0.
REQ-017 SHIFT_HIGH: ctrl_latch=0, ctrl_clk=1 for CLK_DIV cycles; on its last cycle the synchronized ctrl_data is stored, inverted, into shift bit [index]; then SHIFT_LOW.
REQ-018 SHIFT_LOW: ctrl_clk=0 for CLK_DIV cycles; then index increments and FSM returns to SHIFT_HIGH, or enters DONE if index was 15.
REQ-019 DONE (one cycle): buttons <= shift value; buttons_valid=1; pressed_edge <= (read_ack ? 0 : pressed_edge) | (new & ~old buttons); then IDLE.
REQ-020 Frame length from LATCH entry to DONE SHALL be exactly 34*CLK_DIV cycles; DONE is cycle 34*CLK_DIV+1.
REQ-021 read_ack outside DONE SHALL clear pressed_edge to 0 on the next edge; when read_ack coincides with DONE, new edges SHALL survive (set wins).
REQ-022 Half-phase counter and bit index SHALL wrap/reload only as stated; no partial frame SHALL ever update buttons.
REQ-023 ctrl_latch and ctrl_clk SHALL be registered outputs, glitch-free.

Reset
REQ-024 While rst_n=0: FSM=IDLE, ctrl_latch=0, ctrl_clk=1, buttons=0, buttons_valid=0, pressed_edge=0, shift=0, index=0, poll counter=0, synchronizer=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately with no buttons update; polling restarts per REQ-014.

Verification (CLK_DIV=4, POLL_PERIOD=200)
REQ-026 Reset release, ctrl_data held 1 -> ctrl_latch high for 8 cycles starting at cycle 1, 16 ctrl_clk low pulses of 4 cycles each, buttons_valid at cycle 137, buttons=0x0000, pressed_edge=0x0000.
REQ-027 Controller model drives pattern 0xA5C3 (pressed=1, serial bit i on ctrl_data inverted) -> buttons=0xA5C3, pressed_edge=0xA5C3 at buttons_valid; next frame same pattern -> pressed_edge unchanged, no new edges.
REQ-028 pressed_edge=0xA5C3, pulse read_ack mid-IDLE -> pressed_edge=0x0000 next cycle; pattern changes to 0xA5C7 -> pressed_edge=0x0004 after next frame.
REQ-029 read_ack asserted exactly in DONE cycle with new press on bit 15 -> pressed_edge=0x8000, older bits cleared.
REQ-030 rst_n pulsed low during SHIFT_LOW of bit 7 -> outputs take REQ-024 values asynchronously, no buttons_valid, new frame starts first edge after release.
REQ-031 Poll ticks counted over 3 frames -> LATCH entries exactly 200 cycles apart; ctrl_clk never low while ctrl_latch high.
